// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the SRAM-like port arbiter.
// Response IDs name the master that owns an outstanding transaction.
// SRAM size codes: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes.
package sram_like_arbiter_pkg;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    localparam logic [1:0] SIZE_1B = 2'd0;
    localparam logic [1:0] SIZE_2B = 2'd1;
    localparam logic [1:0] SIZE_4B = 2'd2;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_INST = 2'd1,
        GNT_DATA = 2'd2
    } grant_e;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// Bundle of the inst port, data port and shared memory port around the arbiter.
// The slave modport is the arbiter's view; master is the pipeline/bridge view.
// No storage; purely a wiring container.
interface sram_like_arbiter_if;

    // IF-stage inst port (read only)
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    // MEM-stage data port
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    // Shared port toward the bridge
    logic        sram_req;
    logic        sram_wr;
    logic [1:0]  sram_size;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_addr_ok;
    logic        sram_data_ok;
    logic [31:0] sram_rdata;

    modport slave (
        input  inst_sram_req, inst_sram_addr,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
        input  data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        output sram_req, sram_wr, sram_size, sram_wstrb, sram_addr, sram_wdata,
        input  sram_addr_ok, sram_data_ok, sram_rdata
    );

    modport master (
        output inst_sram_req, inst_sram_addr,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
        output data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        input  sram_req, sram_wr, sram_size, sram_wstrb, sram_addr, sram_wdata,
        output sram_addr_ok, sram_data_ok, sram_rdata
    );

endinterface

// File: rtl/sram_like_arbiter_resp_id_fifo.sv
// In-order owner-ID queue for accepted, unanswered memory transactions.
// Push and pop take effect on the clock edge; head/full/empty reflect current state.
// No backpressure of its own: caller must not push when full; pops on empty are ignored.
module sram_like_arbiter_resp_id_fifo #(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             push_id,
    input  logic             pop,
    output logic             head_id,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [DEPTH-1:0] ids;
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head_id = ids[head_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage and pointer/count update; simultaneous push+pop leaves count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ids      <= '0;
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                ids[tail_ptr] <= push_id;
                tail_ptr      <= ptr_next(tail_ptr);
            end
            if (do_pop) begin
                head_ptr <= ptr_next(head_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like port between the inst and data ports; data wins, no lock.
// Zero added latency: grant, addr_ok, data_ok and rdata are combinational pass-through.
// Grant withheld while MAX_OUTSTANDING transactions are pending; responses routed in order.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 4,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             reset,
    sram_like_arbiter_if.slave bus,
    output logic [CNT_W-1:0] outstanding,
    output logic             resp_err
);

    grant_e grant;
    logic   fifo_full;
    logic   fifo_empty;
    logic   head_id;
    logic   accept;
    logic   resp_vld;

    // Address-phase grant, recomputed every cycle; full blocks even if a pop happens now.
    always_comb begin
        grant = GNT_NONE;
        if (!reset && !fifo_full) begin
            if (bus.data_sram_req) begin
                grant = GNT_DATA;
            end else if (bus.inst_sram_req) begin
                grant = GNT_INST;
            end
        end
    end

    // Payload mux onto the shared port; the inst port is always a 4-byte read.
    always_comb begin
        bus.sram_req   = 1'b0;
        bus.sram_wr    = 1'b0;
        bus.sram_size  = 2'b00;
        bus.sram_wstrb = 4'h0;
        bus.sram_addr  = 32'h0;
        bus.sram_wdata = 32'h0;
        case (grant)
            GNT_DATA: begin
                bus.sram_req   = 1'b1;
                bus.sram_wr    = bus.data_sram_wr;
                bus.sram_size  = bus.data_sram_size;
                bus.sram_wstrb = bus.data_sram_wstrb;
                bus.sram_addr  = bus.data_sram_addr;
                bus.sram_wdata = bus.data_sram_wdata;
            end
            GNT_INST: begin
                bus.sram_req   = 1'b1;
                bus.sram_size  = SIZE_4B;
                bus.sram_addr  = bus.inst_sram_addr;
            end
            default: ;
        endcase
    end

    assign accept   = bus.sram_req & bus.sram_addr_ok;
    assign resp_vld = bus.sram_data_ok & ~fifo_empty & ~reset;

    assign bus.inst_sram_addr_ok = (grant == GNT_INST) & bus.sram_addr_ok;
    assign bus.data_sram_addr_ok = (grant == GNT_DATA) & bus.sram_addr_ok;

    assign bus.inst_sram_data_ok = resp_vld & (head_id == ID_INST);
    assign bus.data_sram_data_ok = resp_vld & (head_id == ID_DATA);
    assign bus.inst_sram_rdata   = bus.inst_sram_data_ok ? bus.sram_rdata : 32'h0;
    assign bus.data_sram_rdata   = bus.data_sram_data_ok ? bus.sram_rdata : 32'h0;

    sram_like_arbiter_resp_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_resp_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept),
        .push_id ((grant == GNT_DATA) ? ID_DATA : ID_INST),
        .pop     (resp_vld),
        .head_id (head_id),
        .count   (outstanding),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Sticky flag for a response arriving with nothing outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_err <= 1'b0;
        end else if (bus.sram_data_ok && fifo_empty) begin
            resp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model of ownership and grant priority.
// Inputs change just after the rising edge; outputs are sampled 1 time unit later.
module tb_sram_like_arbiter;

    localparam int MAX = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] outstanding;
    logic       resp_err;

    sram_like_arbiter_if bus();

    sram_like_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .outstanding (outstanding),
        .resp_err    (resp_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of owner IDs (0 = inst, 1 = data) plus sticky error.
    int q[$];
    bit m_err;
    int m_gnt;            // 0 none, 1 inst, 2 data
    logic [139:0] want_v;

    task automatic clear_inputs();
        bus.inst_sram_req   = 1'b0;
        bus.inst_sram_addr  = 32'h0;
        bus.data_sram_req   = 1'b0;
        bus.data_sram_wr    = 1'b0;
        bus.data_sram_size  = 2'b00;
        bus.data_sram_wstrb = 4'h0;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;
        bus.sram_addr_ok    = 1'b0;
        bus.sram_data_ok    = 1'b0;
        bus.sram_rdata      = 32'h0;
    endtask

    // Expected combinational outputs from current inputs and model state.
    task automatic model_eval();
        logic        e_req, e_wr, e_iaok, e_daok, e_idok, e_ddok;
        logic [1:0]  e_size;
        logic [3:0]  e_wstrb;
        logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;
        m_gnt = 0;
        if (!reset && q.size() < MAX) begin
            if (bus.data_sram_req) m_gnt = 2;
            else if (bus.inst_sram_req) m_gnt = 1;
        end
        e_req   = (m_gnt != 0);
        e_wr    = (m_gnt == 2) ? bus.data_sram_wr : 1'b0;
        e_size  = (m_gnt == 2) ? bus.data_sram_size : ((m_gnt == 1) ? 2'b10 : 2'b00);
        e_wstrb = (m_gnt == 2) ? bus.data_sram_wstrb : 4'h0;
        e_addr  = (m_gnt == 2) ? bus.data_sram_addr : ((m_gnt == 1) ? bus.inst_sram_addr : 32'h0);
        e_wdata = (m_gnt == 2) ? bus.data_sram_wdata : 32'h0;
        e_iaok  = (m_gnt == 1) && bus.sram_addr_ok;
        e_daok  = (m_gnt == 2) && bus.sram_addr_ok;
        e_idok  = !reset && bus.sram_data_ok && q.size() > 0 && q[0] == 0;
        e_ddok  = !reset && bus.sram_data_ok && q.size() > 0 && q[0] == 1;
        e_irdata = e_idok ? bus.sram_rdata : 32'h0;
        e_drdata = e_ddok ? bus.sram_rdata : 32'h0;
        want_v = {e_req, e_wr, e_size, e_wstrb, e_addr, e_wdata,
                  e_iaok, e_daok, e_idok, e_ddok, e_irdata, e_drdata};
    endtask

    // Model state update for the coming clock edge: response pops the head, accept appends.
    task automatic model_commit();
        model_eval();
        if (reset) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            if (bus.sram_data_ok) begin
                if (q.size() > 0) void'(q.pop_front());
                else m_err = 1'b1;
            end
            if (m_gnt != 0 && bus.sram_addr_ok) q.push_back(m_gnt == 2 ? 1 : 0);
        end
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        m_err = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        bus.data_sram_req = 1'b1;
        bus.inst_sram_req = 1'b1;
        bus.sram_addr_ok  = 1'b1;
        #2;
        n_checks++;
        if (outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        n_checks++;
        if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %0b want 0", resp_err); end
        n_checks++;
        if (bus.sram_req !== 1'b0 || bus.data_sram_addr_ok !== 1'b0)
            begin n_fail++; $display("FAIL reset_no_grant: req %0b aok %0b want 0 0", bus.sram_req, bus.data_sram_addr_ok); end
        do_reset();
    endtask

    task automatic test_priority();
        do_reset();
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'h0000_0100;
        bus.data_sram_req  = 1'b1;
        bus.data_sram_size = 2'd2;
        bus.data_sram_addr = 32'h0000_0200;
        bus.sram_addr_ok   = 1'b1;
        #1;
        n_checks++;
        if (bus.data_sram_addr_ok !== 1'b1 || bus.inst_sram_addr_ok !== 1'b0 || bus.sram_addr !== 32'h200)
            begin n_fail++; $display("FAIL prio_data_wins: daok %0b iaok %0b addr %h want 1 0 00000200",
                  bus.data_sram_addr_ok, bus.inst_sram_addr_ok, bus.sram_addr); end
        tick();
        bus.data_sram_req = 1'b0;
        #1;
        n_checks++;
        if (bus.inst_sram_addr_ok !== 1'b1 || bus.sram_addr !== 32'h100 || bus.sram_size !== 2'b10)
            begin n_fail++; $display("FAIL prio_inst_next: iaok %0b addr %h size %0d want 1 00000100 2",
                  bus.inst_sram_addr_ok, bus.sram_addr, bus.sram_size); end
        tick();
        clear_inputs();
        #1;
        n_checks++;
        if (outstanding !== 3'd2) begin n_fail++; $display("FAIL prio_count: got %0d want 2", outstanding); end
    endtask

    task automatic test_reset_mid();
        // Two transactions left outstanding by test_priority.
        bus.data_sram_req = 1'b1;
        bus.sram_addr_ok  = 1'b1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (outstanding !== 3'd0 || bus.sram_req !== 1'b0)
            begin n_fail++; $display("FAIL midreset_clear: outst %0d req %0b want 0 0", outstanding, bus.sram_req); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        m_err = 1'b0;
        clear_inputs();
        bus.sram_data_ok = 1'b1;
        bus.sram_rdata   = 32'h1234_5678;
        #1;
        n_checks++;
        if (bus.inst_sram_data_ok !== 1'b0 || bus.data_sram_data_ok !== 1'b0)
            begin n_fail++; $display("FAIL late_resp_routed: idok %0b ddok %0b want 0 0",
                  bus.inst_sram_data_ok, bus.data_sram_data_ok); end
        tick();
        bus.sram_data_ok = 1'b0;
        #1;
        n_checks++;
        if (resp_err !== 1'b1) begin n_fail++; $display("FAIL late_resp_err: got %0b want 1", resp_err); end
        n_checks++;
        if (outstanding !== 3'd0) begin n_fail++; $display("FAIL late_resp_nopop: got %0d want 0", outstanding); end
    endtask

    task automatic test_in_order();
        do_reset();
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'h1c00_0000;
        bus.sram_addr_ok   = 1'b1;
        #1;
        tick();
        bus.inst_sram_req  = 1'b0;
        bus.data_sram_req  = 1'b1;
        bus.data_sram_size = 2'd2;
        bus.data_sram_addr = 32'h1c00_1000;
        #1;
        n_checks++;
        if (bus.sram_addr !== 32'h1c00_1000 || bus.sram_wr !== 1'b0)
            begin n_fail++; $display("FAIL order_load_issue: addr %h wr %0b want 1c001000 0", bus.sram_addr, bus.sram_wr); end
        tick();
        clear_inputs();
        bus.sram_data_ok = 1'b1;
        bus.sram_rdata   = 32'h0000_AAAA;
        #1;
        n_checks++;
        if (bus.inst_sram_data_ok !== 1'b1 || bus.inst_sram_rdata !== 32'hAAAA || bus.data_sram_data_ok !== 1'b0)
            begin n_fail++; $display("FAIL order_first_inst: idok %0b rdata %h ddok %0b want 1 0000aaaa 0",
                  bus.inst_sram_data_ok, bus.inst_sram_rdata, bus.data_sram_data_ok); end
        tick();
        bus.sram_rdata = 32'h0000_BBBB;
        #1;
        n_checks++;
        if (bus.data_sram_data_ok !== 1'b1 || bus.data_sram_rdata !== 32'hBBBB || bus.inst_sram_data_ok !== 1'b0)
            begin n_fail++; $display("FAIL order_second_data: ddok %0b rdata %h idok %0b want 1 0000bbbb 0",
                  bus.data_sram_data_ok, bus.data_sram_rdata, bus.inst_sram_data_ok); end
        tick();
        clear_inputs();
        #1;
        n_checks++;
        if (outstanding !== 3'd0 || resp_err !== 1'b0)
            begin n_fail++; $display("FAIL order_drained: outst %0d err %0b want 0 0", outstanding, resp_err); end
    endtask

    task automatic test_full();
        do_reset();
        bus.data_sram_req  = 1'b1;
        bus.data_sram_addr = 32'h0000_0300;
        bus.sram_addr_ok   = 1'b1;
        repeat (MAX) tick();
        n_checks++;
        if (outstanding !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", outstanding); end
        n_checks++;
        if (bus.sram_req !== 1'b0 || bus.data_sram_addr_ok !== 1'b0)
            begin n_fail++; $display("FAIL full_blocks: req %0b daok %0b want 0 0", bus.sram_req, bus.data_sram_addr_ok); end
        bus.sram_data_ok = 1'b1;
        bus.sram_rdata   = 32'h55;
        #1;
        n_checks++;
        if (bus.sram_req !== 1'b0 || bus.data_sram_data_ok !== 1'b1)
            begin n_fail++; $display("FAIL full_no_bypass: req %0b ddok %0b want 0 1", bus.sram_req, bus.data_sram_data_ok); end
        tick();
        bus.sram_data_ok = 1'b0;
        #1;
        n_checks++;
        if (outstanding !== 3'd3 || bus.sram_req !== 1'b1)
            begin n_fail++; $display("FAIL full_regrant: outst %0d req %0b want 3 1", outstanding, bus.sram_req); end
        tick();
        clear_inputs();
        bus.sram_data_ok = 1'b1;
        repeat (MAX) tick();
        clear_inputs();
        #1;
        n_checks++;
        if (outstanding !== 3'd0 || resp_err !== 1'b0)
            begin n_fail++; $display("FAIL full_drained: outst %0d err %0b want 0 0", outstanding, resp_err); end
    endtask

    task automatic test_push_pop();
        do_reset();
        bus.sram_addr_ok  = 1'b1;
        bus.inst_sram_req = 1'b1;
        #1;
        tick();
        bus.inst_sram_req = 1'b0;
        bus.data_sram_req = 1'b1;
        #1;
        tick();
        bus.sram_data_ok = 1'b1;
        bus.sram_rdata   = 32'h11;
        #1;
        n_checks++;
        if (bus.inst_sram_data_ok !== 1'b1 || bus.inst_sram_rdata !== 32'h11 || bus.data_sram_addr_ok !== 1'b1)
            begin n_fail++; $display("FAIL pp_same_cycle: idok %0b rdata %h daok %0b want 1 00000011 1",
                  bus.inst_sram_data_ok, bus.inst_sram_rdata, bus.data_sram_addr_ok); end
        tick();
        clear_inputs();
        #1;
        n_checks++;
        if (outstanding !== 3'd2) begin n_fail++; $display("FAIL pp_count: got %0d want 2", outstanding); end
        bus.sram_data_ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.sram_rdata = 32'h22 + i;
            #1;
            n_checks++;
            if (bus.data_sram_data_ok !== 1'b1 || bus.data_sram_rdata !== 32'h22 + i)
                begin n_fail++; $display("FAIL pp_route_%0d: ddok %0b rdata %h want 1 %h",
                      i, bus.data_sram_data_ok, bus.data_sram_rdata, 32'h22 + i); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_store();
        do_reset();
        bus.data_sram_req   = 1'b1;
        bus.data_sram_wr    = 1'b1;
        bus.data_sram_size  = 2'd1;
        bus.data_sram_wstrb = 4'b0011;
        bus.data_sram_addr  = 32'h1c00_2002;
        bus.data_sram_wdata = 32'hdead_beef;
        bus.sram_addr_ok    = 1'b1;
        #1;
        n_checks++;
        if ({bus.sram_req, bus.sram_wr, bus.sram_size, bus.sram_wstrb, bus.sram_addr, bus.sram_wdata}
            !== {1'b1, 1'b1, 2'd1, 4'b0011, 32'h1c00_2002, 32'hdead_beef})
            begin n_fail++; $display("FAIL store_payload: req %0b wr %0b size %0d wstrb %b addr %h wdata %h want 1 1 1 0011 1c002002 deadbeef",
                  bus.sram_req, bus.sram_wr, bus.sram_size, bus.sram_wstrb, bus.sram_addr, bus.sram_wdata); end
        tick();
        clear_inputs();
        bus.sram_data_ok = 1'b1;
        #1;
        n_checks++;
        if (bus.data_sram_data_ok !== 1'b1 || bus.inst_sram_data_ok !== 1'b0)
            begin n_fail++; $display("FAIL store_ack: ddok %0b idok %0b want 1 0", bus.data_sram_data_ok, bus.inst_sram_data_ok); end
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        logic [139:0] got_v;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.inst_sram_req   = 1'($urandom_range(0, 1));
            bus.inst_sram_addr  = $urandom;
            bus.data_sram_req   = ($urandom_range(0, 2) == 0);
            bus.data_sram_wr    = 1'($urandom_range(0, 1));
            bus.data_sram_size  = 2'($urandom_range(0, 2));
            bus.data_sram_wstrb = 4'($urandom_range(0, 15));
            bus.data_sram_addr  = $urandom;
            bus.data_sram_wdata = $urandom;
            bus.sram_addr_ok    = 1'($urandom_range(0, 1));
            bus.sram_data_ok    = (q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0);
            bus.sram_rdata      = $urandom;
            #1;
            model_eval();
            got_v = {bus.sram_req, bus.sram_wr, bus.sram_size, bus.sram_wstrb, bus.sram_addr, bus.sram_wdata,
                     bus.inst_sram_addr_ok, bus.data_sram_addr_ok, bus.inst_sram_data_ok, bus.data_sram_data_ok,
                     bus.inst_sram_rdata, bus.data_sram_rdata};
            n_checks++;
            if (got_v !== want_v) begin n_fail++; $display("FAIL rand_outputs cycle %0d: got %h want %h", c, got_v, want_v); end
            n_checks++;
            if (outstanding !== 3'(q.size()) || resp_err !== m_err)
                begin n_fail++; $display("FAIL rand_state cycle %0d: outst %0d err %0b want %0d %0b",
                      c, outstanding, resp_err, q.size(), m_err); end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b0;
        m_err = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_priority();
        test_reset_mid();
        test_in_order();
        test_full();
        test_push_pop();
        test_store();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
